// File: rtl/mmio_timer_if.sv
// Load/store data-port bundle between the core (master) and the mmio_timer responder (slave).
`timescale 1ns/1ps

interface mmio_timer_if;
    logic        W_en;
    logic        R_en;
    logic [2:0]  RW_type;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output W_en, R_en, RW_type, addr, din, input dout);
    modport slave  (input W_en, R_en, RW_type, addr, din, output dout);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare-match, W1C pending flag and level interrupt.
// Define MMIO_TIMER_IRQ_EN to build the irq path (CTRL.IRQEN storage and the registered irq output).
`timescale 1ns/1ps

module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    mmio_timer_if.slave  bus,
    output logic         irq
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_STATUS   = 3'd4
    } reg_idx_e;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q, pend_d;
    logic [15:0] psc_cnt_q, psc_cnt_d;

    logic        sel;
    logic [2:0]  reg_idx;
    logic [31:0] rd_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic [31:0] wr_word;
    logic        wr;
    logic        tick;
    logic        match;

    assign sel     = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign reg_idx = bus.addr[4:2];

    // Register read mux and load extraction.
    // NOTE: every variable in an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_word = '0;
        case (reg_idx)
            REG_CTRL:     rd_word = {29'd0, ctrl_q};
            REG_PRESCALE: rd_word = {16'd0, prescale_q};
            REG_COUNT:    rd_word = count_q;
            REG_COMPARE:  rd_word = compare_q;
            REG_STATUS:   rd_word = {31'd0, pend_q};
            default:      rd_word = '0;
        endcase

        ld_byte = '0;
        case (bus.addr[1:0])
            2'd0: ld_byte = rd_word[7:0];
            2'd1: ld_byte = rd_word[15:8];
            2'd2: ld_byte = rd_word[23:16];
            2'd3: ld_byte = rd_word[31:24];
            default: ld_byte = '0;
        endcase
        ld_half = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];

        load_data = '0;
        case (bus.RW_type)
            F3_B:  load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU: load_data = {24'd0, ld_byte};
            F3_H:  load_data = bus.addr[0] ? 32'd0 : {{16{ld_half[15]}}, ld_half};
            F3_HU: load_data = bus.addr[0] ? 32'd0 : {16'd0, ld_half};
            F3_W:  load_data = (bus.addr[1:0] == 2'b00) ? rd_word : 32'd0;
            default: load_data = '0;
        endcase
    end

    assign bus.dout = (sel && bus.R_en) ? load_data : 32'd0;

    // Store lane enables; a misaligned or unsupported store yields no lanes and is dropped.
    always_comb begin
        be    = 4'b0000;
        wdata = bus.din;
        case (bus.RW_type)
            F3_B: begin
                be    = 4'b0001 << bus.addr[1:0];
                wdata = {4{bus.din[7:0]}};
            end
            F3_H: begin
                if (!bus.addr[0]) be = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.din[15:0]}};
            end
            F3_W: begin
                if (bus.addr[1:0] == 2'b00) be = 4'b1111;
            end
            default: be = 4'b0000;
        endcase
        mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wr_word = (rd_word & ~mask) | (wdata & mask);
        wr      = sel && bus.W_en && (|be);
    end

    assign tick  = ctrl_q[0] && (psc_cnt_q == prescale_q);
    assign match = (count_q == compare_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        pend_d     = pend_q;
        psc_cnt_d  = psc_cnt_q;

        if (tick) count_d = (match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;

        if (wr) begin
            case (reg_idx)
                REG_CTRL:     ctrl_d     = wr_word[2:0];
                REG_PRESCALE: prescale_d = wr_word[15:0];
                REG_COUNT:    count_d    = wr_word;
                REG_COMPARE:  compare_d  = wr_word;
                REG_STATUS:   if (wr_word[0]) pend_d = 1'b0;
                default:      ;
            endcase
        end
`ifndef MMIO_TIMER_IRQ_EN
        ctrl_d[2] = 1'b0;
`endif

        // A match set is applied after the W1C so it wins a same-cycle clear.
        if (tick && match) pend_d = 1'b1;

        if ((wr && reg_idx == REG_PRESCALE) || !ctrl_d[0] || tick) begin
            psc_cnt_d = 16'd0;
        end else if (ctrl_q[0]) begin
            psc_cnt_d = psc_cnt_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            pend_q     <= 1'b0;
            psc_cnt_q  <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            pend_q     <= pend_d;
            psc_cnt_q  <= psc_cnt_d;
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    logic irq_q, irq_d;

    // Registered from next-state PEND and IRQEN so it rises with the match edge.
    always_comb begin
        irq_d = pend_d && ctrl_d[2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
